fetch_stage: RTL and testbench

// Instruction fetch stage, directly downstream of the program counter. Takes pcValue, issues a

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_fetch_stage.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : request FSM states (REQ, WAIT, FULL)
//   NOP_INSTR     : instruction word presented while the IF/ID entry is empty
//   RESET_PC      : boot address, shared with the program counter
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for a response that arrives while
// decode is stalled on a live IF/ID entry.
//   clock, reset     : clock and synchronous active-high reset (buffer empty)
//   wrEn             : capture wrInstr/wrPc, buffer becomes full
//   rdEn             : consume the entry, buffer becomes empty
//   clear            : discard the entry (dominates wrEn/rdEn)
//   wrInstr, wrPc    : entry to capture
//   full             : buffer holds an entry
//   rdInstr, rdPc    : buffered entry
module fetch_skid_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic              clear,
  input  logic [DATA_W-1:0] wrInstr,
  input  logic [ADDR_W-1:0] wrPc,
  output logic              full,
  output logic [DATA_W-1:0] rdInstr,
  output logic [ADDR_W-1:0] rdPc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      full    <= 1'b0;
      rdInstr <= '0;
      rdPc    <= '0;
    end else begin
      if (clear) begin
        full <= 1'b0;
      end else if (wrEn) begin
        full <= 1'b1;
      end else if (rdEn) begin
        full <= 1'b0;
      end
      if (wrEn && !clear) begin
        rdInstr <= wrInstr;
        rdPc    <= wrPc;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one valid/ready request at a time to
// instruction memory, captures the response into the IF/ID register, and
// releases the PC (pcHold=0) only when an instruction retires or on a jump.
//   clock, reset          : clock and synchronous active-high reset
//   pcValue               : current PC (bits [1:0] ignored)
//   pcHold                : 0 lets the PC load its next/jump value this edge
//   flush                 : jump taken this cycle, squashes in-flight work
//   imemReq*              : fetch request channel (valid/ready/address)
//   imemResp*             : instruction response (latency >= 1 cycle)
//   stallIn               : decode cannot accept a new IF/ID entry
//   ifidValid/Instr/Pc/PcPlus4 : IF/ID pipeline register
module fetch_stage #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(fetch_pkg::NOP_INSTR)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pcValue,
  output logic              pcHold,
  input  logic              flush,
  output logic              imemReqValid,
  input  logic              imemReqReady,
  output logic [ADDR_W-1:0] imemReqAddr,
  input  logic              imemRespValid,
  input  logic [DATA_W-1:0] imemRespData,
  input  logic              stallIn,
  output logic              ifidValid,
  output logic [DATA_W-1:0] ifidInstr,
  output logic [ADDR_W-1:0] ifidPc,
  output logic [ADDR_W-1:0] ifidPcPlus4
);

  import fetch_pkg::*;

  fetch_state_e      state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic              slot_free;
  logic              retire_resp, buf_wr, buf_rd;
  logic              buf_full;
  logic [DATA_W-1:0] buf_instr;
  logic [ADDR_W-1:0] buf_pc;
  logic              unused_pc_bits;

  assign imemReqAddr    = {pcValue[ADDR_W-1:2], 2'b00};
  assign unused_pc_bits = ^pcValue[1:0];
  assign slot_free      = !ifidValid || !stallIn;

  // State register and drop flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= REQ;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next state. drop marks an outstanding request whose response must be
  // discarded because a jump overtook it.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      REQ: begin
        if (imemReqReady) begin
          state_d = WAIT;
          if (flush) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          // A response arriving with the flush is the outstanding one:
          // nothing remains in flight afterwards.
          if (imemRespValid) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imemRespValid) begin
          if (drop_q) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else if (slot_free) begin
            state_d = REQ;
          end else begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (flush || !stallIn) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  // Outputs and internal strobes decoded from the current state.
  always_comb begin
    imemReqValid = 1'b0;
    pcHold       = 1'b1;
    retire_resp  = 1'b0;
    buf_wr       = 1'b0;
    buf_rd       = 1'b0;
    if (!reset) begin
      imemReqValid = (state_q == REQ);
      retire_resp  = (state_q == WAIT) && imemRespValid && !drop_q && !flush && slot_free;
      buf_wr       = (state_q == WAIT) && imemRespValid && !drop_q && !flush && !slot_free;
      buf_rd       = (state_q == FULL) && buf_full && !stallIn && !flush;
      pcHold       = !(retire_resp || buf_rd || flush);
    end
  end

  // Address of the request in flight, committed on the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_pc_q <= '0;
    end else if (imemReqValid && imemReqReady) begin
      req_pc_q <= imemReqAddr;
    end
  end

  // IF/ID register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ifidValid   <= 1'b0;
      ifidInstr   <= NOP_INSTR;
      ifidPc      <= '0;
      ifidPcPlus4 <= '0;
    end else if (flush) begin
      ifidValid <= 1'b0;
      ifidInstr <= NOP_INSTR;
    end else if (retire_resp) begin
      ifidValid   <= 1'b1;
      ifidInstr   <= imemRespData;
      ifidPc      <= req_pc_q;
      ifidPcPlus4 <= req_pc_q + ADDR_W'(4);
    end else if (buf_rd) begin
      ifidValid   <= 1'b1;
      ifidInstr   <= buf_instr;
      ifidPc      <= buf_pc;
      ifidPcPlus4 <= buf_pc + ADDR_W'(4);
    end else if (!stallIn) begin
      ifidValid <= 1'b0;
      ifidInstr <= NOP_INSTR;
    end
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .wrEn    (buf_wr),
    .rdEn    (buf_rd),
    .clear   (flush),
    .wrInstr (imemRespData),
    .wrPc    (req_pc_q),
    .full    (buf_full),
    .rdInstr (buf_instr),
    .rdPc    (buf_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC register and instruction memory live in the bench;
// a program-order scoreboard tracks which fetched words are owed to IF/ID.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pcValue = RST_PC;
  logic        pcHold;
  logic        flush = 1'b0;
  logic        imemReqValid;
  logic        imemReqReady = 1'b0;
  logic [31:0] imemReqAddr;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData = 32'h0;
  logic        stallIn = 1'b0;
  logic        ifidValid;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPc;
  logic [31:0] ifidPcPlus4;

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock         (clock),
    .reset         (reset),
    .pcValue       (pcValue),
    .pcHold        (pcHold),
    .flush         (flush),
    .imemReqValid  (imemReqValid),
    .imemReqReady  (imemReqReady),
    .imemReqAddr   (imemReqAddr),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .stallIn       (stallIn),
    .ifidValid     (ifidValid),
    .ifidInstr     (ifidInstr),
    .ifidPc        (ifidPc),
    .ifidPcPlus4   (ifidPcPlus4)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_loads  = 0;
  int          lat_lo   = 1;
  int          lat_hi   = 1;
  logic [31:0] pc_model = RST_PC;
  logic [31:0] prog_pc  = RST_PC;
  bit          mem_pend = 1'b0;
  int          mem_due  = 0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_epoch = 0;
  int          epoch    = 0;
  entry_t      owed[$];
  bit          prev_valid = 1'b0;
  logic [31:0] prev_instr, prev_pc, prev_p4;
  logic        s_req_valid, s_hold;
  logic [31:0] s_req_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3004) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // One clock: drive inputs, sample combinational outputs, advance the
  // environment (PC, memory) and the program-order scoreboard.
  task automatic cycle(input logic rst, input logic rdy, input logic stl,
                       input logic fl, input logic [31:0] tgt);
    logic   hs, resp, held, newe;
    entry_t e;
    resp          = !rst && mem_pend && (cyc >= mem_due);
    reset         = rst;
    imemReqReady  = rdy;
    stallIn       = stl;
    flush         = fl;
    pcValue       = pc_model;
    imemRespValid = resp;
    imemRespData  = resp ? mem_word(mem_addr) : 32'h0BAD_0BAD;
    #1;
    s_req_valid = imemReqValid;
    s_req_addr  = imemReqAddr;
    s_hold      = pcHold;
    hs          = imemReqValid && rdy;
    if (rst) begin
      n_checks++;
      if (imemReqValid !== 1'b0 || pcHold !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_outputs: reqValid=%b pcHold=%b expected 0/1", imemReqValid, pcHold);
      end
    end else if (imemReqValid === 1'b1) begin
      n_checks++;
      if (imemReqAddr !== {pc_model[31:2], 2'b00}) begin
        n_fail++;
        $display("FAIL req_addr: got %h expected %h", imemReqAddr, {pc_model[31:2], 2'b00});
      end
      n_checks++;
      if (hs && mem_pend) begin
        n_fail++;
        $display("FAIL one_outstanding: got request %h expected none while %h pending", imemReqAddr, mem_addr);
      end
    end
    @(posedge clock);
    @(negedge clock);
    if (rst) begin
      pc_model = RST_PC;
      prog_pc  = RST_PC;
      mem_pend = 1'b0;
      owed.delete();
      epoch++;
      n_checks++;
      if (ifidValid !== 1'b0 || ifidInstr !== NOP || ifidPc !== 32'h0 || ifidPcPlus4 !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_ifid: got v=%b i=%h pc=%h p4=%h expected 0/%h/0/0",
                 ifidValid, ifidInstr, ifidPc, ifidPcPlus4, NOP);
      end
    end else begin
      if (resp) begin
        mem_pend = 1'b0;
        if (!fl && mem_epoch == epoch) begin
          n_checks++;
          if (mem_addr !== prog_pc) begin
            n_fail++;
            $display("FAIL prog_order: fetched %h expected %h", mem_addr, prog_pc);
          end
          prog_pc = mem_addr + 32'd4;
          owed.push_back('{mem_addr, mem_word(mem_addr)});
        end
      end
      if (hs) begin
        mem_pend  = 1'b1;
        mem_addr  = {pc_model[31:2], 2'b00};
        mem_due   = cyc + int'($urandom_range(lat_hi, lat_lo));
        mem_epoch = epoch;
      end
      if (fl) begin
        owed.delete();
        epoch++;
        prog_pc = {tgt[31:2], 2'b00};
      end
      if (fl) pc_model = tgt;
      else if (!s_hold) pc_model = pc_model + 32'd4;

      held = prev_valid && stl && !fl;
      newe = (ifidValid === 1'b1) && !held;
      n_checks++;
      if (fl) begin
        if (ifidValid !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_clears: ifidValid=%b expected 0", ifidValid);
        end
      end else if (held) begin
        if (ifidValid !== 1'b1 || ifidInstr !== prev_instr || ifidPc !== prev_pc || ifidPcPlus4 !== prev_p4) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b i=%h pc=%h expected 1/%h/%h",
                   ifidValid, ifidInstr, ifidPc, prev_instr, prev_pc);
        end
      end else if (newe) begin
        n_loads++;
        if (owed.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_load: got pc=%h expected no load", ifidPc);
        end else begin
          e = owed.pop_front();
          if (ifidPc !== e.pc || ifidInstr !== e.instr || ifidPcPlus4 !== e.pc + 32'd4) begin
            n_fail++;
            $display("FAIL ifid_load: got %h@%h p4=%h expected %h@%h p4=%h",
                     ifidInstr, ifidPc, ifidPcPlus4, e.instr, e.pc, e.pc + 32'd4);
          end
        end
      end else if (ifidValid !== 1'b0) begin
        n_fail++;
        $display("FAIL ifid_bubble: ifidValid=%b expected 0", ifidValid);
      end
      if (ifidValid === 1'b0) begin
        n_checks++;
        if (ifidInstr !== NOP) begin
          n_fail++;
          $display("FAIL nop_instr: got %h expected %h", ifidInstr, NOP);
        end
      end
      n_checks++;
      if (!(owed.size() == 0 || (owed.size() == 1 && stl && prev_valid))) begin
        n_fail++;
        $display("FAIL lost_entry: %0d owed entries expected delivery", owed.size());
      end
      n_checks++;
      if (s_hold !== !(fl || newe)) begin
        n_fail++;
        $display("FAIL pc_hold: got %b expected %b", s_hold, !(fl || newe));
      end
    end
    prev_valid = (ifidValid === 1'b1);
    prev_instr = ifidInstr;
    prev_pc    = ifidPc;
    prev_p4    = ifidPcPlus4;
    cyc++;
  endtask

  task automatic do_reset();
    lat_lo = 1;
    lat_hi = 1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (s_req_valid !== 1'b0 || s_hold !== 1'b1 || ifidValid !== 1'b0 || ifidInstr !== NOP) begin
        n_fail++;
        $display("FAIL test_reset: req=%b hold=%b v=%b i=%h expected 0/1/0/%h",
                 s_req_valid, s_hold, ifidValid, ifidInstr, NOP);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1/%h", s_req_valid, s_req_addr, RST_PC);
    end
  endtask

  task automatic test_sequence();
    logic        exp_v;
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      exp_v  = (i % 2 == 1);
      exp_pc = RST_PC + 32'(4 * (i / 2));
      n_checks++;
      if (ifidValid !== exp_v || s_hold !== !exp_v) begin
        n_fail++;
        $display("FAIL seq_pulse[%0d]: v=%b hold=%b expected %b/%b", i, ifidValid, s_hold, exp_v, !exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (ifidPc !== exp_pc || ifidInstr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("FAIL seq_pc[%0d]: got %h@%h expected %h@%h", i, ifidInstr, ifidPc, mem_word(exp_pc), exp_pc);
        end
      end
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC || s_hold !== 1'b1 || ifidValid !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_low[%0d]: req=%b addr=%h hold=%b v=%b expected 1/%h/1/0",
                 i, s_req_valid, s_req_addr, s_hold, ifidValid, RST_PC);
      end
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifidValid !== 1'b1 || ifidPc !== RST_PC) begin
      n_fail++;
      $display("FAIL ready_resume: v=%b pc=%h expected 1/%h", ifidValid, ifidPc, RST_PC);
    end
  endtask

  task automatic test_stall_buffer();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (ifidValid !== 1'b1 || ifidPc !== RST_PC || s_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_resp: v=%b pc=%h hold=%b expected 1/%h/1", ifidValid, ifidPc, s_hold, RST_PC);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    n_checks++;
    if (s_req_valid !== 1'b0 || s_hold !== 1'b1 || ifidPc !== RST_PC) begin
      n_fail++;
      $display("FAIL stall_full: req=%b hold=%b pc=%h expected 0/1/%h", s_req_valid, s_hold, ifidPc, RST_PC);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_hold !== 1'b0 || ifidValid !== 1'b1 || ifidInstr !== 32'hDEAD_BEEF ||
        ifidPc !== 32'h0000_3004 || ifidPcPlus4 !== 32'h0000_3008) begin
      n_fail++;
      $display("FAIL stall_release: hold=%b got %h@%h p4=%h expected 0 DEADBEEF@00003004 p4=00003008",
               s_hold, ifidInstr, ifidPc, ifidPcPlus4);
    end
  endtask

  task automatic test_flush_wait();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    lat_lo = 3;
    lat_hi = 3;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    lat_lo = 1;
    lat_hi = 1;
    n_checks++;
    if (s_req_addr !== 32'h0000_3008) begin
      n_fail++;
      $display("FAIL flush_wait_req: addr=%h expected 00003008", s_req_addr);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_4000);
    n_checks++;
    if (s_hold !== 1'b0 || ifidValid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_wait: hold=%b v=%b expected 0/0", s_hold, ifidValid);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifidValid !== 1'b0 || s_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_dropped: v=%b hold=%b expected 0/1", ifidValid, s_hold);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL flush_target_req: req=%b addr=%h expected 1/00004000", s_req_valid, s_req_addr);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifidValid !== 1'b1 || ifidPc !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL flush_target_load: v=%b pc=%h expected 1/00004000", ifidValid, ifidPc);
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_5000);
    n_checks++;
    if (s_hold !== 1'b0 || ifidValid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: hold=%b v=%b expected 0/0", s_hold, ifidValid);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_5000 || ifidValid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full_resume: req=%b addr=%h v=%b expected 1/00005000/0",
               s_req_valid, s_req_addr, ifidValid);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifidValid !== 1'b1 || ifidPc !== 32'h0000_5000) begin
      n_fail++;
      $display("FAIL flush_full_load: v=%b pc=%h expected 1/00005000", ifidValid, ifidPc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req: addr=%h expected fffffffc", s_req_addr);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifidValid !== 1'b1 || ifidPc !== 32'hFFFF_FFFC || ifidPcPlus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_p4: v=%b pc=%h p4=%h expected 1/fffffffc/00000000", ifidValid, ifidPc, ifidPcPlus4);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: addr=%h expected 00000000", s_req_addr);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_6002);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_req_addr !== 32'h0000_6000) begin
      n_fail++;
      $display("FAIL addr_align: addr=%h expected 00006000", s_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, RST_PC);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_hold !== 1'b1 || s_req_valid !== 1'b0 || ifidValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: hold=%b req=%b v=%b expected 1/0/0", s_hold, s_req_valid, ifidValid);
    end
    lat_lo = 1;
    lat_hi = 1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_mid_req: req=%b addr=%h expected 1/%h", s_req_valid, s_req_addr, RST_PC);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (ifidValid !== 1'b1 || ifidPc !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_mid_drop: v=%b pc=%h expected 1/%h", ifidValid, ifidPc, RST_PC);
    end
  endtask

  task automatic test_random();
    int          loads0;
    logic        rst, rdy, stl, fl;
    logic [31:0] tgt;
    do_reset();
    lat_lo = 1;
    lat_hi = 4;
    loads0 = n_loads;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(199, 0) == 0);
      rdy = ($urandom_range(9, 0) < 7);
      stl = ($urandom_range(9, 0) < 3);
      fl  = ($urandom_range(99, 0) < 6);
      tgt = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF8 : $urandom;
      cycle(rst, rdy, stl, fl, tgt);
    end
    n_checks++;
    if (n_loads - loads0 < 200) begin
      n_fail++;
      $display("FAIL random_progress: %0d loads expected at least 200", n_loads - loads0);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_sequence();
    test_ready_low();
    test_stall_buffer();
    test_flush_wait();
    test_flush_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
